// File: rtl/serial_paralelo_phy_rx_pkg.sv
// Shared PHY definitions: symbol width, COM idle/alignment symbol, receiver states.
// The TX parallel->serial stage uses the same values, so they live here instead of in phy_defs.vh.
package serial_paralelo_phy_rx_pkg;

  localparam int unsigned PHY_WIDTH = 8;
  localparam logic [7:0]  PHY_COM   = 8'hBC;

  // Receiver link states; the encoding matches the former 2-bit localparams.
  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } phy_state_e;

endpackage

// File: rtl/serial_paralelo_phy_rx_com_detector.sv
// Serial-in shift register with a COM comparator on the registered window.
module com_detector
  import serial_paralelo_phy_rx_pkg::*;
#(
  parameter int unsigned      WIDTH = PHY_WIDTH,
  parameter logic [WIDTH-1:0] COM   = WIDTH'(PHY_COM)
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] sr,
  output logic             is_com
);

  // Shift the serial line in MSB first; the newest bit lands in bit 0.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      sr <= '0;
    end else begin
      sr <= {sr[WIDTH-2:0], data_in};
    end
  end

  // The comparison uses the registered window, so a byte is judged one edge after its last bit.
  always_comb begin
    is_com = (sr == COM);
  end

endmodule

// File: rtl/serial_paralelo_phy_rx.sv
// RX deserializer: finds byte alignment on COM, locks after LOCK_COUNT aligned COMs,
// then delivers data bytes with a strobe at every byte boundary (COM = idle).
module serial_paralelo_phy_rx
  import serial_paralelo_phy_rx_pkg::*;
#(
  parameter int unsigned      WIDTH      = PHY_WIDTH,
  parameter logic [WIDTH-1:0] COM        = WIDTH'(PHY_COM),
  parameter int unsigned      LOCK_COUNT = 4
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             byte_strobe,
  output logic             active
);

  localparam int unsigned BCW  = $clog2(LOCK_COUNT + 1);
  localparam int unsigned BITW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] sr;
  logic             is_com;
  logic [BITW-1:0]  bit_cnt;
  logic [BITW-1:0]  bit_next;
  logic [BCW-1:0]   bc_cnt;
  logic             boundary;
  phy_state_e       state;

  com_detector #(
    .WIDTH (WIDTH),
    .COM   (COM)
  ) u_com_detector (
    .clk_32f (clk_32f),
    .reset   (reset),
    .data_in (data_in),
    .sr      (sr),
    .is_com  (is_com)
  );

  // Bit position within the current symbol; a boundary is where sr holds a whole aligned byte.
  always_comb begin
    bit_next = (bit_cnt == BITW'(WIDTH - 1)) ? '0 : bit_cnt + 1'b1;
    boundary = (bit_cnt == '0);
  end

  // Link FSM with registered outputs: hunts COM at every bit offset, then tracks byte boundaries.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state       <= SEARCH;
      bit_cnt     <= '0;
      bc_cnt      <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
      active      <= 1'b0;
    end else begin
      byte_strobe <= 1'b0;
      unique case (state)
        SEARCH: begin
          bit_cnt <= '0;
          if (is_com) begin
            // The matched COM defines the phase: next boundary is WIDTH edges later.
            bc_cnt  <= BCW'(1);
            bit_cnt <= BITW'(1);
            if (LOCK_COUNT == 1) begin
              state  <= ACTIVE;
              active <= 1'b1;
            end else begin
              state <= ALIGN;
            end
          end
        end
        ALIGN: begin
          bit_cnt <= bit_next;
          if (boundary) begin
            if (is_com) begin
              if (bc_cnt != '1) begin
                bc_cnt <= bc_cnt + 1'b1;
              end
              if (32'(bc_cnt) + 1 == LOCK_COUNT) begin
                state  <= ACTIVE;
                active <= 1'b1;
              end
            end else begin
              state   <= SEARCH;
              bc_cnt  <= '0;
              bit_cnt <= '0;
            end
          end
        end
        ACTIVE: begin
          bit_cnt <= bit_next;
          if (boundary) begin
            byte_strobe <= 1'b1;
            if (is_com) begin
              valid_out <= 1'b0;
            end else begin
              data_out  <= sr;
              valid_out <= 1'b1;
            end
          end
        end
        default: begin
          state <= SEARCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_paralelo_phy_rx.sv
// Self-checking bench for serial_paralelo_phy_rx: expected bytes are queued as they are
// sent and compared (value, validity and arrival cycle) when byte_strobe fires.
module tb_serial_paralelo_phy_rx;

  localparam logic [7:0] BC = 8'hBC;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       valid;
  } exp_t;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         last_cyc = 0;
  int         act_cyc  = 0;
  bit         act_seen = 1'b0;
  bit         mon_on   = 1'b0;
  logic [7:0] cur_data = 8'h00;
  logic       cur_valid = 1'b0;
  exp_t       sb[$];

  serial_paralelo_phy_rx #(
    .WIDTH      (8),
    .COM        (8'hBC),
    .LOCK_COUNT (4)
  ) dut (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .data_in     (data_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .byte_strobe (byte_strobe),
    .active      (active)
  );

  always #5 clk_32f = ~clk_32f;

  always @(posedge clk_32f) cyc <= cyc + 1;

  // Scoreboard monitor: pops on every strobe, otherwise checks that outputs are held.
  always @(negedge clk_32f) begin
    if (mon_on) begin
      if (active === 1'b1 && !act_seen) begin
        act_seen = 1'b1;
        act_cyc  = cyc;
      end
      if (byte_strobe === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_strobe: cycle %0d got data=%h valid=%b, required no strobe",
                   cyc, data_out, valid_out);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (cyc !== e.cyc || data_out !== e.data || valid_out !== e.valid) begin
            failures++;
            $display("FAIL byte_out: got cycle=%0d data=%h valid=%b, required cycle=%0d data=%h valid=%b",
                     cyc, data_out, valid_out, e.cyc, e.data, e.valid);
          end
          cur_data  = e.data;
          cur_valid = e.valid;
        end
      end else begin
        checks++;
        if (data_out !== cur_data || valid_out !== cur_valid) begin
          failures++;
          $display("FAIL hold: cycle %0d got data=%h valid=%b, required data=%h valid=%b",
                   cyc, data_out, valid_out, cur_data, cur_valid);
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    data_in = b;
    @(posedge clk_32f);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit push,
                           input logic [7:0] ed, input logic ev);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk_32f);
      data_in = b[i];
      if (i == 7 && push) sb.push_back('{cyc + 9, ed, ev});
      if (i == 0) last_cyc = cyc + 1;
      @(posedge clk_32f);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_32f);
    reset   = 1'b1;
    data_in = 1'($urandom_range(0, 1));
    @(posedge clk_32f);
    #1;
    sb.delete();
    cur_data  = 8'h00;
    cur_valid = 1'b0;
    act_seen  = 1'b0;
    mon_on    = 1'b1;
    @(negedge clk_32f);
    reset   = 1'b0;
    data_in = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 6 && !done; i++) begin
      @(negedge clk_32f);
      #1;
      if (sb.size() == 0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_missing_strobe: got %0d bytes still pending, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    @(negedge clk_32f);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = 1'($urandom_range(0, 1));
      @(posedge clk_32f);
      #1;
      if (i == 0) begin
        sb.delete();
        cur_data  = 8'h00;
        cur_valid = 1'b0;
        act_seen  = 1'b0;
        mon_on    = 1'b1;
      end
      checks += 4;
      if (data_out !== 8'h00) begin
        failures++; $display("FAIL reset_data_out: got %h required 00", data_out);
      end
      if (valid_out !== 1'b0) begin
        failures++; $display("FAIL reset_valid_out: got %b required 0", valid_out);
      end
      if (byte_strobe !== 1'b0) begin
        failures++; $display("FAIL reset_byte_strobe: got %b required 0", byte_strobe);
      end
      if (active !== 1'b0) begin
        failures++; $display("FAIL reset_active: got %b required 0", active);
      end
      @(negedge clk_32f);
    end
    reset   = 1'b0;
    data_in = 1'b0;
  endtask

  task automatic test_lock();
    int lc;
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(BC, 1'b0, 8'h00, 1'b0);
    lc = last_cyc;
    checks++;
    if (act_seen !== 1'b0) begin
      failures++; $display("FAIL lock_active_early: got active at cycle %0d, required after %0d", act_cyc, lc);
    end
    send_byte(8'h5A, 1'b1, 8'h5A, 1'b1);
    send_byte(8'hC3, 1'b1, 8'hC3, 1'b1);
    send_byte(BC,    1'b1, 8'hC3, 1'b0);
    drain("lock");
    checks++;
    if (!act_seen || act_cyc !== lc + 1) begin
      failures++; $display("FAIL lock_active_cycle: got %0d (seen=%b) required %0d", act_cyc, act_seen, lc + 1);
    end
  endtask

  task automatic test_phase_offset();
    int lc;
    do_reset();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    for (int i = 0; i < 4; i++) send_byte(BC, 1'b0, 8'h00, 1'b0);
    lc = last_cyc;
    send_byte(8'h0F, 1'b1, 8'h0F, 1'b1);
    send_byte(BC,    1'b1, 8'h0F, 1'b0);
    drain("phase");
    checks++;
    if (!act_seen || act_cyc !== lc + 1) begin
      failures++; $display("FAIL phase_active_cycle: got %0d (seen=%b) required %0d", act_cyc, act_seen, lc + 1);
    end
  endtask

  task automatic test_relock_fail();
    int lc;
    do_reset();
    for (int i = 0; i < 3; i++) send_byte(BC, 1'b0, 8'h00, 1'b0);
    send_byte(8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(BC, 1'b0, 8'h00, 1'b0);
    lc = last_cyc;
    send_byte(8'h5A, 1'b1, 8'h5A, 1'b1);
    send_byte(BC,    1'b1, 8'h5A, 1'b0);
    drain("relock");
    checks++;
    if (!act_seen || act_cyc !== lc + 1) begin
      failures++; $display("FAIL relock_active_cycle: got %0d (seen=%b) required %0d", act_cyc, act_seen, lc + 1);
    end
  endtask

  task automatic test_active_stream();
    logic [7:0] tx [6] = '{8'hFF, BC,    8'h11, 8'h0B, 8'hC0, BC};
    logic [7:0] ed [6] = '{8'hFF, 8'hFF, 8'h11, 8'h0B, 8'hC0, 8'hC0};
    logic       ev [6] = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0};
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(BC, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) send_byte(tx[i], 1'b1, ed[i], ev[i]);
    drain("stream");
  endtask

  task automatic test_mid_reset();
    int lc;
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(BC, 1'b0, 8'h00, 1'b0);
    send_byte(8'h5A, 1'b1, 8'h5A, 1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge clk_32f);
    reset   = 1'b1;
    data_in = 1'b1;
    @(posedge clk_32f);
    #1;
    checks += 4;
    if (active !== 1'b0) begin
      failures++; $display("FAIL midreset_active: got %b required 0", active);
    end
    if (valid_out !== 1'b0) begin
      failures++; $display("FAIL midreset_valid_out: got %b required 0", valid_out);
    end
    if (data_out !== 8'h00) begin
      failures++; $display("FAIL midreset_data_out: got %h required 00", data_out);
    end
    if (byte_strobe !== 1'b0) begin
      failures++; $display("FAIL midreset_byte_strobe: got %b required 0", byte_strobe);
    end
    sb.delete();
    cur_data  = 8'h00;
    cur_valid = 1'b0;
    act_seen  = 1'b0;
    @(negedge clk_32f);
    reset   = 1'b0;
    data_in = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(BC, 1'b0, 8'h00, 1'b0);
    lc = last_cyc;
    send_byte(8'h3C, 1'b1, 8'h3C, 1'b1);
    send_byte(BC,    1'b1, 8'h3C, 1'b0);
    drain("midreset");
    checks++;
    if (!act_seen || act_cyc !== lc + 1) begin
      failures++; $display("FAIL midreset_relock_cycle: got %0d (seen=%b) required %0d", act_cyc, act_seen, lc + 1);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_phase_offset();
    test_relock_fail();
    test_active_stream();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
